biquad_cascade: RTL and testbench
=================================

BIQUAD_CASCADE -- requirements
Module: biquad_cascade

Interface
REQ-001 SHALL have parameter IN_W, default 10: signed width of x_adc and y_n.
REQ-002 SHALL have parameter WHOLE_BITS, default 10: integer bits of the internal state word.
REQ-003 SHALL have parameter FRAC_BITS, default 32: fractional bits of the internal state word (W = WHOLE_BITS+FRAC_BITS).
REQ-004 SHALL have parameter COEFF_W, default 32: signed coefficient width.
REQ-005 SHALL have parameter COEFF_FRAC, default 30: coefficient fractional bits (default range [-2,2)).
REQ-006 SHALL have parameter NUM_SECTIONS, default 2, legal 1..8: number of cascaded second-order sections.
REQ-007 SHALL use one clock and a synchronous, active-high reset.
REQ-008 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-009 SHALL have port reset, input, 1: synchronous, active-high.
REQ-010 SHALL have port x_adc, input, IN_W: signed sample.
REQ-011 SHALL have port sample_ready, input, 1: x_adc is valid this cycle.
REQ-012 SHALL have port coefficients_ready, input, 1: coefficient set usable; samples are not accepted while low.
REQ-013 SHALL have port coeff_wr, input, 1: coefficient write strobe.
REQ-014 SHALL have port coeff_addr, input, 6: address = 5*section+k; k: 0 b0, 1 b1, 2 b2, 3 a1, 4 a2.
REQ-015 SHALL have port coeff_data, input, COEFF_W: signed coefficient value.
REQ-016 SHALL have port y_n, output, IN_W: signed filtered output.
REQ-017 SHALL have port valid_out, output, 1: one-cycle pulse, y_n updated.
REQ-018 SHALL have port busy, output, 1: high while a sample is in computation.
REQ-019 SHALL have port overflow, output, 1: pulses with valid_out if any saturation occurred for that sample.
REQ-020 SHALL have port sample_drop, output, 1: one-cycle pulse, sample_ready was ignored.
REQ-021 SHALL have port coeff_err, output, 1: one-cycle pulse, coeff_wr was rejected.

Function
REQ-022 SHALL implement per section s (Direct Form I): y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2; section s output is section s+1 input.
REQ-023 SHALL sign-extend x_adc to WHOLE_BITS integer bits with FRAC_BITS zero fraction on accept.
REQ-024 SHALL form each product full-precision, arithmetic-shift it right by COEFF_FRAC, and sum in W+4 bits.
REQ-025 SHALL saturate each section result to W-bit signed before storing it or passing it on.
REQ-026 SHALL form y_n as the last section result, arithmetic-shifted right by FRAC_BITS (floor), then saturated to IN_W signed.
REQ-027 SHALL use a two-state FSM IDLE/RUN, with busy = (state==RUN).
REQ-028 SHALL accept a sample at an edge where state==IDLE and sample_ready=1 and coefficients_ready=1; that edge moves to RUN with section counter 0.
REQ-029 In RUN SHALL compute one section per cycle using a single shared MAC datapath, updating that section's x1/x2/y1/y2 at the same edge.
REQ-030 SHALL, at the edge computing section NUM_SECTIONS-1, register y_n, pulse valid_out and overflow, and return to IDLE.
REQ-031 SHALL have latency of NUM_SECTIONS cycles from the accept edge to valid_out high, and throughput of one sample per NUM_SECTIONS+1 cycles.
REQ-032 SHALL hold y_n between valid_out pulses.
REQ-033 SHALL pulse sample_drop for sample_ready=1 while in RUN, or while coefficients_ready=0; such samples are not processed.
REQ-034 SHALL apply coeff_wr at the edge when state==IDLE; coeff_wr in RUN, or with coeff_addr >= 5*NUM_SECTIONS, SHALL be ignored with a coeff_err pulse.
REQ-035 SHALL apply a coeff_wr and a sample accept at the same edge both; the accepted sample uses the new coefficient.
REQ-036 SHALL keep overflow low when valid_out is low.

Reset
REQ-037 SHALL on reset: state IDLE; y_n=0; valid_out, busy, overflow, sample_drop, coeff_err all 0; all x1/x2/y1/y2 = 0.
REQ-038 SHALL on reset set coefficients to passthrough: b0 = 1.0 (1<<COEFF_FRAC), all others 0.
REQ-039 SHALL let reset asserted mid-RUN abort the sample with no valid_out and take precedence over every other input.

Verification
REQ-040 Bench SHALL cover: defaults after reset, x_adc=511 accepted -> valid_out 2 cycles later, y_n=511, overflow=0.
REQ-041 Bench SHALL cover: NUM_SECTIONS=1, b0=0.5; inputs 511 then -511 -> y_n=255, then -256.
REQ-042 Bench SHALL cover: NUM_SECTIONS=1, b0=1.0, a1=-0.5; impulse 256 then zeros -> y_n=256,128,64,32,16,...
REQ-043 Bench SHALL cover: b0=1.99 (one section, rest passthrough), x_adc=511 -> y_n=511, overflow=1; x_adc=-512 -> y_n=-512, overflow=1.
REQ-044 Bench SHALL cover: sample_ready held high continuously -> one accept per NUM_SECTIONS+1 cycles, sample_drop in every busy cycle; coeff_wr during busy -> coeff_err=1 and coefficient unchanged.
REQ-045 Bench SHALL cover: reset asserted one cycle after accept -> no valid_out, busy=0 next cycle, coefficients return to passthrough.

Source files
------------

// File: rtl/biquad_cascade.sv
`default_nettype none
// =====================================================================
// Module   : biquad_cascade
// Purpose  : Cascade of NUM_SECTIONS Direct Form I second-order sections
//            sharing one MAC datapath. The design evaluates one section
//            per clock and saturates at every section boundary.
// Revision : 1.0 - initial release
// =====================================================================
module biquad_cascade #(
    parameter int IN_W         = 10,
    parameter int WHOLE_BITS   = 10,
    parameter int FRAC_BITS    = 32,
    parameter int COEFF_W      = 32,
    parameter int COEFF_FRAC   = 30,
    parameter int NUM_SECTIONS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [IN_W-1:0]    x_adc,
    input  logic                      sample_ready,
    input  logic                      coefficients_ready,
    input  logic                      coeff_wr,
    input  logic [5:0]                coeff_addr,
    input  logic signed [COEFF_W-1:0] coeff_data,
    output logic signed [IN_W-1:0]    y_n,
    output logic                      valid_out,
    output logic                      busy,
    output logic                      overflow,
    output logic                      sample_drop,
    output logic                      coeff_err
);

    localparam int c_W         = WHOLE_BITS + FRAC_BITS;
    localparam int c_ACC_W     = c_W + 4;
    localparam int c_PROD_W    = c_W + COEFF_W;
    localparam int c_GUARD     = c_ACC_W - c_W + 1;
    localparam int c_OUT_GUARD = c_W - IN_W + 1;
    localparam int c_SEC_W     = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;

    localparam logic [5:0]         c_NUM_COEFFS = 6'(5 * NUM_SECTIONS);
    localparam logic [c_SEC_W-1:0] c_LAST_SEC   = c_SEC_W'(NUM_SECTIONS - 1);
    localparam logic [COEFF_W-1:0] c_ONE        = COEFF_W'(1) << COEFF_FRAC;
    localparam logic [c_W-1:0]     c_SAT_MAX    = {1'b0, {(c_W-1){1'b1}}};
    localparam logic [c_W-1:0]     c_SAT_MIN    = {1'b1, {(c_W-1){1'b0}}};
    localparam logic [IN_W-1:0]    c_Y_MAX      = {1'b0, {(IN_W-1){1'b1}}};
    localparam logic [IN_W-1:0]    c_Y_MIN      = {1'b1, {(IN_W-1){1'b0}}};

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]                r_state;
    logic [c_SEC_W-1:0]        r_sec;
    logic                      r_ovf_acc;
    logic signed [c_W-1:0]     r_sample;
    logic signed [COEFF_W-1:0] r_coef [NUM_SECTIONS][5];
    logic signed [c_W-1:0]     r_x1 [NUM_SECTIONS];
    logic signed [c_W-1:0]     r_x2 [NUM_SECTIONS];
    logic signed [c_W-1:0]     r_y1 [NUM_SECTIONS];
    logic signed [c_W-1:0]     r_y2 [NUM_SECTIONS];

    logic signed [IN_W-1:0]    r_y_n;
    logic                      r_valid;
    logic                      r_ovf;
    logic                      r_drop;
    logic                      r_cerr;

    logic signed [c_W-1:0]      w_x_ext;
    logic signed [c_W-1:0]      w_xin, w_x1, w_x2, w_y1, w_y2;
    logic signed [COEFF_W-1:0]  w_b0, w_b1, w_b2, w_a1, w_a2;
    logic signed [c_PROD_W-1:0] w_p_b0, w_p_b1, w_p_b2, w_p_a1, w_p_a2;
    logic signed [c_ACC_W-1:0]  w_t_b0, w_t_b1, w_t_b2, w_t_a1, w_t_a2;
    logic signed [c_ACC_W-1:0]  w_acc;
    logic                       w_sat;
    logic signed [c_W-1:0]      w_sec_out;
    logic signed [c_W-1:0]      w_shift;
    logic                       w_osat;
    logic signed [IN_W-1:0]     w_yq;
    logic                       w_coef_addr_ok;

    // Accepted sample becomes a fixed-point word with an all-zero fraction
    assign w_x_ext        = c_W'(x_adc) <<< FRAC_BITS;
    assign w_coef_addr_ok = (coeff_addr < c_NUM_COEFFS);

    assign busy        = (r_state == c_RUN);
    assign y_n         = r_y_n;
    assign valid_out   = r_valid;
    assign overflow    = r_ovf;
    assign sample_drop = r_drop;
    assign coeff_err   = r_cerr;

    // Route the active section's history and coefficients onto the shared MAC
    always_comb begin
        w_xin = r_sample;
        w_x1  = '0;
        w_x2  = '0;
        w_y1  = '0;
        w_y2  = '0;
        w_b0  = '0;
        w_b1  = '0;
        w_b2  = '0;
        w_a1  = '0;
        w_a2  = '0;
        for (int s = 0; s < NUM_SECTIONS; s++) begin
            if (r_sec == c_SEC_W'(s)) begin
                w_x1 = r_x1[s];
                w_x2 = r_x2[s];
                w_y1 = r_y1[s];
                w_y2 = r_y2[s];
                w_b0 = r_coef[s][0];
                w_b1 = r_coef[s][1];
                w_b2 = r_coef[s][2];
                w_a1 = r_coef[s][3];
                w_a2 = r_coef[s][4];
                // Later sections take the previous section's freshly stored output
                if (s > 0) w_xin = r_y1[(s > 0) ? s - 1 : 0];
            end
        end
    end

    // Full-precision products, rescaled to the state format, summed with guard bits
    always_comb begin
        w_p_b0 = c_PROD_W'(w_b0) * c_PROD_W'(w_xin);
        w_p_b1 = c_PROD_W'(w_b1) * c_PROD_W'(w_x1);
        w_p_b2 = c_PROD_W'(w_b2) * c_PROD_W'(w_x2);
        w_p_a1 = c_PROD_W'(w_a1) * c_PROD_W'(w_y1);
        w_p_a2 = c_PROD_W'(w_a2) * c_PROD_W'(w_y2);
        w_t_b0 = c_ACC_W'(w_p_b0 >>> COEFF_FRAC);
        w_t_b1 = c_ACC_W'(w_p_b1 >>> COEFF_FRAC);
        w_t_b2 = c_ACC_W'(w_p_b2 >>> COEFF_FRAC);
        w_t_a1 = c_ACC_W'(w_p_a1 >>> COEFF_FRAC);
        w_t_a2 = c_ACC_W'(w_p_a2 >>> COEFF_FRAC);
        w_acc  = w_t_b0 + w_t_b1 + w_t_b2 - w_t_a1 - w_t_a2;
    end

    // Clamp the section result to the state word, then derive the integer output
    always_comb begin
        w_sat     = (w_acc[c_ACC_W-1:c_W-1] != {c_GUARD{w_acc[c_ACC_W-1]}});
        w_sec_out = w_sat ? (w_acc[c_ACC_W-1] ? c_SAT_MIN : c_SAT_MAX) : w_acc[c_W-1:0];
        w_shift   = w_sec_out >>> FRAC_BITS;
        w_osat    = (w_shift[c_W-1:IN_W-1] != {c_OUT_GUARD{w_shift[c_W-1]}});
        w_yq      = w_osat ? (w_shift[c_W-1] ? c_Y_MIN : c_Y_MAX) : w_shift[IN_W-1:0];
    end

    // Control FSM, coefficient bank, per-section history and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_sec     <= '0;
            r_ovf_acc <= 1'b0;
            r_sample  <= '0;
            r_y_n     <= '0;
            r_valid   <= 1'b0;
            r_ovf     <= 1'b0;
            r_drop    <= 1'b0;
            r_cerr    <= 1'b0;
            for (int s = 0; s < NUM_SECTIONS; s++) begin
                r_x1[s] <= '0;
                r_x2[s] <= '0;
                r_y1[s] <= '0;
                r_y2[s] <= '0;
                r_coef[s][0] <= c_ONE;
                for (int k = 1; k < 5; k++) r_coef[s][k] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_cerr  <= 1'b0;
            r_drop  <= sample_ready && ((r_state == c_RUN) || !coefficients_ready);

            // Writes land only between samples so a computation never sees a mixed set
            if (coeff_wr) begin
                if ((r_state == c_IDLE) && w_coef_addr_ok) begin
                    for (int s = 0; s < NUM_SECTIONS; s++) begin
                        for (int k = 0; k < 5; k++) begin
                            if (coeff_addr == 6'(5 * s + k)) r_coef[s][k] <= coeff_data;
                        end
                    end
                end else begin
                    r_cerr <= 1'b1;
                end
            end

            case (r_state)
                c_IDLE: begin
                    if (sample_ready && coefficients_ready) begin
                        r_sample  <= w_x_ext;
                        r_sec     <= '0;
                        r_ovf_acc <= 1'b0;
                        r_state   <= c_RUN;
                    end
                end
                c_RUN: begin
                    for (int s = 0; s < NUM_SECTIONS; s++) begin
                        if (r_sec == c_SEC_W'(s)) begin
                            r_x1[s] <= w_xin;
                            r_x2[s] <= r_x1[s];
                            r_y1[s] <= w_sec_out;
                            r_y2[s] <= r_y1[s];
                        end
                    end
                    if (r_sec == c_LAST_SEC) begin
                        r_y_n   <= w_yq;
                        r_valid <= 1'b1;
                        r_ovf   <= r_ovf_acc | w_sat | w_osat;
                        r_state <= c_IDLE;
                    end else begin
                        r_sec     <= r_sec + 1'b1;
                        r_ovf_acc <= r_ovf_acc | w_sat;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_biquad_cascade.sv
`default_nettype none
// =====================================================================
// Module   : tb_biquad_cascade
// Purpose  : Self-checking bench. Two instances (two sections and one
//            section) see the same stimulus, and each is compared with
//            an arithmetic reference of the filter equations.
// Revision : 1.0 - initial release
// =====================================================================
module tb_biquad_cascade;

    localparam int     c_IN_W  = 10;
    localparam int     c_FRAC  = 32;
    localparam int     c_CF    = 30;
    localparam int     c_W     = 42;
    localparam longint c_SMAX  = (longint'(1) <<< (c_W - 1)) - 1;
    localparam longint c_SMIN  = -(longint'(1) <<< (c_W - 1));
    localparam longint c_ONE   = longint'(1) <<< c_CF;
    localparam int     c_NS [2] = '{2, 1};

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic signed [c_IN_W-1:0] x_adc = '0;
    logic                     sample_ready = 1'b0;
    logic                     coefficients_ready = 1'b1;
    logic                     coeff_wr = 1'b0;
    logic [5:0]               coeff_addr = '0;
    logic signed [31:0]       coeff_data = '0;

    logic signed [c_IN_W-1:0] y_n [2];
    logic                     valid_out [2];
    logic                     busy [2];
    logic                     overflow [2];
    logic                     sample_drop [2];
    logic                     coeff_err [2];

    int n_checks = 0;
    int n_fail   = 0;

    longint mc  [2][10];
    longint mx1 [2][2];
    longint mx2 [2][2];
    longint my1 [2][2];
    longint my2 [2][2];

    int obs_y  [2];
    bit obs_ov [2];

    always #5 clk = ~clk;

    biquad_cascade #(.NUM_SECTIONS(2)) dut_a (
        .clk(clk), .reset(reset), .x_adc(x_adc), .sample_ready(sample_ready),
        .coefficients_ready(coefficients_ready), .coeff_wr(coeff_wr),
        .coeff_addr(coeff_addr), .coeff_data(coeff_data),
        .y_n(y_n[0]), .valid_out(valid_out[0]), .busy(busy[0]),
        .overflow(overflow[0]), .sample_drop(sample_drop[0]), .coeff_err(coeff_err[0])
    );

    biquad_cascade #(.NUM_SECTIONS(1)) dut_b (
        .clk(clk), .reset(reset), .x_adc(x_adc), .sample_ready(sample_ready),
        .coefficients_ready(coefficients_ready), .coeff_wr(coeff_wr),
        .coeff_addr(coeff_addr), .coeff_data(coeff_data),
        .y_n(y_n[1]), .valid_out(valid_out[1]), .busy(busy[1]),
        .overflow(overflow[1]), .sample_drop(sample_drop[1]), .coeff_err(coeff_err[1])
    );

    task automatic check(input string tag, input int d, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0d expected %0d", tag, d, obs, exp);
        end
    endtask

    // Reference: passthrough coefficients and cleared history
    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 10; a++) mc[d][a] = 0;
            for (int s = 0; s < 2; s++) begin
                mc[d][5*s] = c_ONE;
                mx1[d][s] = 0; mx2[d][s] = 0; my1[d][s] = 0; my2[d][s] = 0;
            end
        end
    endtask

    function automatic logic signed [127:0] term(input longint c, input longint v);
        logic signed [127:0] a;
        logic signed [127:0] b;
        a = c;
        b = v;
        return (a * b) >>> c_CF;
    endfunction

    // Reference: one sample through the whole cascade of instance d
    task automatic model_sample(input int d, input int x, output int y, output bit ov);
        longint v;
        longint o;
        longint ys;
        logic signed [127:0] acc;
        ov = 1'b0;
        v  = longint'(x) <<< c_FRAC;
        for (int s = 0; s < c_NS[d]; s++) begin
            acc = term(mc[d][5*s], v) + term(mc[d][5*s+1], mx1[d][s]) + term(mc[d][5*s+2], mx2[d][s])
                - term(mc[d][5*s+3], my1[d][s]) - term(mc[d][5*s+4], my2[d][s]);
            if (acc > c_SMAX) begin
                o = c_SMAX; ov = 1'b1;
            end else if (acc < c_SMIN) begin
                o = c_SMIN; ov = 1'b1;
            end else begin
                o = longint'(acc);
            end
            mx2[d][s] = mx1[d][s]; mx1[d][s] = v;
            my2[d][s] = my1[d][s]; my1[d][s] = o;
            v = o;
        end
        ys = v >>> c_FRAC;
        if (ys > 511) begin
            ys = 511; ov = 1'b1;
        end else if (ys < -512) begin
            ys = -512; ov = 1'b1;
        end
        y = int'(ys);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; sample_ready = 1'b0; coeff_wr = 1'b0; coefficients_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wcoef(input int addr, input longint data);
        @(negedge clk);
        coeff_wr = 1'b1; coeff_addr = 6'(addr); coeff_data = 32'(data);
        @(negedge clk);
        coeff_wr = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("coeff_err_on_write", d, coeff_err[d], (addr >= 5 * c_NS[d]) ? 1 : 0);
            if (addr < 5 * c_NS[d]) mc[d][addr] = data;
        end
    endtask

    // One sample, optionally with a coefficient write on the same edge
    task automatic send(input int x, input bit wr, input int addr, input longint data);
        int ey [2];
        bit eo [2];
        int lat [2];
        @(negedge clk);
        x_adc = c_IN_W'(x); sample_ready = 1'b1;
        coeff_wr = wr; coeff_addr = 6'(addr); coeff_data = 32'(data);
        @(negedge clk);
        sample_ready = 1'b0; coeff_wr = 1'b0;
        for (int d = 0; d < 2; d++) begin
            if (wr) begin
                check("same_edge_coeff_err", d, coeff_err[d], (addr >= 5 * c_NS[d]) ? 1 : 0);
                if (addr < 5 * c_NS[d]) mc[d][addr] = data;
            end
            model_sample(d, x, ey[d], eo[d]);
            lat[d] = 0;
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check("overflow_without_valid", d, overflow[d] & ~valid_out[d], 0);
                if (valid_out[d] && lat[d] == 0) begin
                    lat[d] = c; obs_y[d] = y_n[d]; obs_ov[d] = overflow[d];
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            check("latency", d, lat[d], c_NS[d]);
            check("y_n", d, obs_y[d], ey[d]);
            check("overflow", d, obs_ov[d], eo[d]);
        end
    endtask

    initial begin
        longint k;
        int     xr;
        model_reset();

        // Reset state and passthrough defaults
        do_reset();
        for (int d = 0; d < 2; d++) begin
            check("rst_y_n", d, y_n[d], 0);
            check("rst_valid", d, valid_out[d], 0);
            check("rst_busy", d, busy[d], 0);
            check("rst_overflow", d, overflow[d], 0);
            check("rst_drop", d, sample_drop[d], 0);
            check("rst_cerr", d, coeff_err[d], 0);
        end
        send(511, 1'b0, 0, 0);
        for (int d = 0; d < 2; d++) begin
            check("pass_511", d, obs_y[d], 511);
            check("pass_511_ovf", d, obs_ov[d], 0);
        end

        // Half gain, floor rounding
        do_reset();
        wcoef(0, longint'(1) <<< 29);
        send(511, 1'b0, 0, 0);
        for (int d = 0; d < 2; d++) check("half_pos", d, obs_y[d], 255);
        send(-511, 1'b0, 0, 0);
        for (int d = 0; d < 2; d++) check("half_neg", d, obs_y[d], -256);

        // First-order recursion: impulse response halves each sample
        do_reset();
        wcoef(3, -(longint'(1) <<< 29));
        send(256, 1'b0, 0, 0);
        for (int d = 0; d < 2; d++) check("impulse_0", d, obs_y[d], 256);
        for (int n = 1; n <= 5; n++) begin
            send(0, 1'b0, 0, 0);
            for (int d = 0; d < 2; d++) check("impulse_n", d, obs_y[d], 256 >>> n);
        end

        // Saturation at both rails
        do_reset();
        wcoef(0, 2136746230);
        send(511, 1'b0, 0, 0);
        for (int d = 0; d < 2; d++) begin
            check("sat_pos", d, obs_y[d], 511);
            check("sat_pos_ovf", d, obs_ov[d], 1);
        end
        send(-512, 1'b0, 0, 0);
        for (int d = 0; d < 2; d++) begin
            check("sat_neg", d, obs_y[d], -512);
            check("sat_neg_ovf", d, obs_ov[d], 1);
        end

        // Address range and same-edge write plus accept
        do_reset();
        wcoef(5, c_ONE);
        wcoef(10, 12345);
        wcoef(63, 12345);
        send(400, 1'b1, 0, longint'(1) <<< 29);
        for (int d = 0; d < 2; d++) check("same_edge_gain", d, obs_y[d], 200);

        // Samples refused while coefficients are not ready
        do_reset();
        @(negedge clk);
        coefficients_ready = 1'b0; sample_ready = 1'b1; x_adc = 10'sd100;
        @(negedge clk);
        sample_ready = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("nocoef_drop", d, sample_drop[d], 1);
            check("nocoef_busy", d, busy[d], 0);
        end
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) check("nocoef_no_valid", d, valid_out[d], 0);
        end
        coefficients_ready = 1'b1;

        // Coefficient write while busy is rejected and has no effect
        do_reset();
        @(negedge clk);
        x_adc = 10'sd200; sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        coeff_wr = 1'b1; coeff_addr = 6'd0; coeff_data = 32'(longint'(1) <<< 29);
        for (int d = 0; d < 2; d++) check("busy_after_accept", d, busy[d], 1);
        @(negedge clk);
        coeff_wr = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("busy_coeff_err", d, coeff_err[d], 1);
            model_sample(d, 200, obs_y[d], obs_ov[d]);
        end
        repeat (3) @(negedge clk);
        send(200, 1'b0, 0, 0);
        for (int d = 0; d < 2; d++) check("coef_unchanged", d, obs_y[d], 200);

        // Continuous sample_ready: accept period NS+1, drops while busy
        do_reset();
        @(negedge clk);
        x_adc = 10'sd10; sample_ready = 1'b1;
        for (int e = 0; e < 30; e++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check("stream_valid", d, valid_out[d], (e % (c_NS[d] + 1)) == c_NS[d] ? 1 : 0);
                check("stream_drop", d, sample_drop[d], (e % (c_NS[d] + 1)) != 0 ? 1 : 0);
                check("stream_busy", d, busy[d], (e % (c_NS[d] + 1)) != c_NS[d] ? 1 : 0);
            end
        end
        sample_ready = 1'b0;

        // Reset one cycle after accept aborts and restores passthrough
        do_reset();
        wcoef(0, 1610612736);
        @(negedge clk);
        x_adc = 10'sd100; sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("abort_busy", d, busy[d], 0);
            check("abort_valid", d, valid_out[d], 0);
        end
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) check("abort_no_valid", d, valid_out[d], 0);
        end
        model_reset();
        send(100, 1'b0, 0, 0);
        for (int d = 0; d < 2; d++) check("abort_passthrough", d, obs_y[d], 100);

        // Random coefficients and samples against the reference
        do_reset();
        k = 644245094;
        for (int a = 0; a < 10; a++) wcoef(a, longint'($urandom_range(0, 32'(2 * k))) - k);
        for (int n = 0; n < 25; n++) begin
            xr = int'($urandom_range(0, 1023)) - 512;
            send(xr, 1'b0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
